// File: rtl/sqrt_pkg.sv
// Shared constants for the square-root pipeline and its sequencer.
//   SQRT_W        width of the square/delta stage registers
//   SQRT_STAGES   default number of controlled pipeline stages
//   SQ_INIT       value a cleared square register holds
//   DELTA_INIT    value a cleared delta register holds
//   clog2()       ceiling log2, usable in parameter expressions
package sqrt_pkg;

    localparam int unsigned SQRT_W      = 9;
    localparam int unsigned SQRT_STAGES = 4;

    localparam logic [SQRT_W-1:0] SQ_INIT    = 9'd4;
    localparam logic [SQRT_W-1:0] DELTA_INIT = 9'd3;

    // Returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sqrt_stage_slot.sv
// One pipeline stage slot: a valid bit plus its advance and enable terms.
// Ports:
//   clock_i      system clock, rising edge
//   reset_i      synchronous active-high reset
//   flush_i      synchronous flush, clears the valid bit
//   src_valid_i  valid of the upstream source (in_valid or previous stage)
//   adv_next_i   downstream can make room this cycle
//   valid_o      registered valid bit of this stage
//   adv_o        this stage may take new contents this cycle
//   en_o         load enable for this stage's register bank
module sqrt_stage_slot (
    input  logic clock_i,
    input  logic reset_i,
    input  logic flush_i,
    input  logic src_valid_i,
    input  logic adv_next_i,
    output logic valid_o,
    output logic adv_o,
    output logic en_o
);

    logic v_q, v_d;

    // An empty slot can always take new contents; a full one only if it moves on.
    assign adv_o   = !v_q | adv_next_i;
    // Bubbles advance as v=0 without enabling the data registers.
    assign en_o    = adv_o & src_valid_i & !flush_i & !reset_i;
    assign valid_o = v_q;

    always_comb begin
        v_d = v_q;
        if (adv_o) begin
            v_d = src_valid_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

endmodule

// File: rtl/sqrt_pipe_ctrl.sv
// Pipeline sequencer for the square-root datapath stage registers.
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   in_valid / in_ready  operand handshake at stage 0
//   out_valid/out_ready  result handshake at the last stage
//   flush                synchronous pipeline flush
//   stage_en             per-stage register load enables
//   stage_clr            per-stage clear strobes (load init constants)
//   occupancy            number of valid stages
//   done_cnt             delivered results, wraps modulo 2^CNT_W
//   busy                 occupancy != 0
module sqrt_pipe_ctrl
    import sqrt_pkg::*;
#(
    parameter  int unsigned STAGES = SQRT_STAGES,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned OCC_W  = clog2(STAGES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_clr,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  done_cnt,
    output logic              busy
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] adv_next;

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        logic src_valid;

        if (i == 0) begin : g_src_in
            assign src_valid = in_valid;
        end else begin : g_src_prev
            assign src_valid = v[i-1];
        end

        // Closed form of the ripple adv[i+1]: downstream moves unless every
        // later stage is full and the sink is stalling.
        if (i == STAGES - 1) begin : g_adv_last
            assign adv_next[i] = out_ready;
        end else begin : g_adv_mid
            assign adv_next[i] = out_ready | ~(&v[STAGES-1:i+1]);
        end

        sqrt_stage_slot u_slot (
            .clock_i     (clock),
            .reset_i     (reset),
            .flush_i     (flush),
            .src_valid_i (src_valid),
            .adv_next_i  (adv_next[i]),
            .valid_o     (v[i]),
            .adv_o       (adv[i]),
            .en_o        (stage_en[i])
        );
    end

    assign in_ready  = adv[0] & !flush & !reset;
    assign out_valid = v[STAGES-1];
    assign stage_clr = {STAGES{reset | flush}};

    logic in_fire, out_fire;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready & !flush & !reset;

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] done_q, done_d;

    always_comb begin
        occ_d  = occ_q;
        done_d = done_q;
        case ({in_fire, out_fire})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        if (out_fire) begin
            done_d = done_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q  <= '0;
            done_q <= '0;
        end else if (flush) begin
            occ_q  <= '0;
            done_q <= done_q;
        end else begin
            occ_q  <= occ_d;
            done_q <= done_d;
        end
    end

    assign occupancy = occ_q;
    assign done_cnt  = done_q;
    assign busy      = (occ_q != '0);

endmodule

// File: tb/tb_sqrt_pipe_ctrl.sv
module tb_sqrt_pipe_ctrl;

    localparam int unsigned STAGES = 4;
    localparam int unsigned CNT_W  = 4;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_clr;
    logic [2:0]       occupancy;
    logic [CNT_W-1:0] done_cnt;
    logic             busy;

    sqrt_pipe_ctrl #(
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .stage_en  (stage_en),
        .stage_clr (stage_clr),
        .occupancy (occupancy),
        .done_cnt  (done_cnt),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [STAGES-1:0] mv;
    int                mocc;
    int                mdone;
    int                cyc;
    bit                lat_on;
    int                sbq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_cycle(input logic rst, input logic iv, input logic ordy, input logic fl);
        logic [STAGES-1:0] madv, e_en, nv;
        logic              a, e_ir, inc, dec;
        int                acc;
        reset     = rst;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        #3;
        a = ordy;
        for (int i = STAGES - 1; i >= 0; i--) begin
            madv[i] = !mv[i] | a;
            a       = madv[i];
        end
        e_ir = madv[0] & !fl & !rst;
        for (int i = 0; i < STAGES; i++) begin
            if (i == 0) e_en[i] = madv[i] & iv & !fl & !rst;
            else        e_en[i] = madv[i] & mv[i-1] & !fl & !rst;
        end
        check("in_ready",  32'(in_ready),  32'(e_ir));
        check("out_valid", 32'(out_valid), 32'(mv[STAGES-1]));
        check("stage_en",  32'(stage_en),  32'(e_en));
        check("stage_clr", 32'(stage_clr), (rst || fl) ? 32'hF : 32'h0);
        check("occupancy", 32'(occupancy), 32'(mocc));
        check("occ_pop",   32'(occupancy), 32'($countones(mv)));
        check("done_cnt",  32'(done_cnt),  32'(mdone));
        check("busy",      32'(busy),      32'(mocc != 0));

        // Scoreboard: accept cycles queued in, popped on each delivered result.
        if (iv && e_ir) sbq.push_back(cyc);
        if (out_valid && ordy && !fl && !rst) begin
            check("sb_has_entry", 32'(out_valid), 32'(sbq.size() != 0));
            if (sbq.size() != 0) begin
                acc = sbq.pop_front();
                if (lat_on) check("latency", 32'(cyc - acc), 32'(STAGES));
            end
        end

        @(posedge clock);
        if (rst) begin
            mv = '0; mocc = 0; mdone = 0; sbq.delete();
        end else if (fl) begin
            mv = '0; mocc = 0; sbq.delete();
        end else begin
            nv = mv;
            for (int i = 0; i < STAGES; i++) begin
                if (madv[i]) nv[i] = (i == 0) ? iv : mv[i-1];
            end
            inc  = iv & e_ir;
            dec  = mv[STAGES-1] & ordy;
            mocc = mocc + int'(inc) - int'(dec);
            if (dec) mdone = (mdone + 1) % (1 << CNT_W);
            mv = nv;
        end
        cyc++;
        #1;
    endtask

    initial begin
        mv = '0; mocc = 0; mdone = 0; cyc = 0; lat_on = 1'b1;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clock);
        #1;

        // Reset held two cycles.
        do_cycle(1, 0, 0, 0);
        do_cycle(1, 1, 1, 0);
        do_cycle(0, 0, 0, 0);

        // Streaming, then drain.
        for (int k = 0; k < 10; k++) do_cycle(0, 1, 1, 0);
        for (int k = 0; k < 5; k++)  do_cycle(0, 0, 1, 0);
        check("stream_done", 32'(done_cnt), 32'(10));
        check("stream_drained", 32'(sbq.size()), 32'(0));

        // Backpressure: fill and stall, then release.
        lat_on = 1'b0;
        for (int k = 0; k < 10; k++) do_cycle(0, 1, 0, 0);
        check("bp_full", 32'(occupancy), 32'(STAGES));
        for (int k = 0; k < 6; k++)  do_cycle(0, 0, 1, 0);
        check("bp_drained", 32'(sbq.size()), 32'(0));
        lat_on = 1'b1;

        // Bubbles.
        for (int k = 0; k < 8; k++) do_cycle(0, (k % 2) == 0, 1, 0);
        for (int k = 0; k < 5; k++) do_cycle(0, 0, 1, 0);

        // Flush mid-stream with occupancy 3.
        for (int k = 0; k < 3; k++) do_cycle(0, 1, 1, 0);
        check("pre_flush_occ", 32'(occupancy), 32'(3));
        do_cycle(0, 1, 1, 1);
        do_cycle(0, 0, 1, 0);

        // Counter wrap from a fresh reset: 17 results -> done_cnt=1.
        do_cycle(1, 0, 0, 0);
        for (int k = 0; k < 17; k++) do_cycle(0, 1, 1, 0);
        for (int k = 0; k < 5; k++)  do_cycle(0, 0, 1, 0);
        check("wrap", 32'(done_cnt), 32'(1));

        // Random traffic with occasional flushes.
        lat_on = 1'b0;
        for (int k = 0; k < 60; k++) begin
            do_cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 15) == 0);
        end
        for (int k = 0; k < 6; k++) do_cycle(0, 0, 1, 0);
        check("final_drained", 32'(sbq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
